sr_flip_flop: RTL and testbench
===============================

// Module: sr_flip_flop
// PURPOSE
//   Bank of WIDTH clocked set/reset flip-flops sharing one clock and one reset.
//   Each bit holds, sets, or clears on the rising clk edge according to its s/r pair.
//   The s=r=1 case follows a build-time policy instead of being undefined.
//   General-purpose state/flag storage: status latches, sticky event bits, control flags.
// PARAMETERS
//   WIDTH      1     number of independent SR bits (>=1)
//   RST_VAL    '0    per-bit value loaded into q while reset is asserted
//   SR_POLICY  HOLD  s=r=1 action (srff_pkg::sr_policy_e): HOLD, SET_DOM, RST_DOM, TOGGLE
// PORTS
//   clk      in   1      rising-edge clock
//   rst      in   1      asynchronous, active-low reset
//   en       in   1      clock enable; 0 = all bits hold
//   s        in   WIDTH  per-bit set request
//   r        in   WIDTH  per-bit reset request
//   q        out  WIDTH  registered state
//   qbar     out  WIDTH  always ~q (combinational from q, never independently stored)
//   illegal  out  1      registered pulse: some bit saw s=r=1 with en=1 on previous edge
// BEHAVIOUR
//   - rst=0: immediately (no clock needed) q=RST_VAL, qbar=~RST_VAL, illegal=0.
//     Held while low; s/r/en ignored.
//   - rst release: first capture on the first rising clk edge with rst=1.
//   - Per bit, on posedge clk with en=1:
//     s=0 r=0 -> hold; s=0 r=1 -> q=0; s=1 r=0 -> q=1; s=1 r=1 -> SR_POLICY.
//   - SR_POLICY actions: HOLD keeps q, SET_DOM q=1, RST_DOM q=0, TOGGLE q=~q.
//   - en=0: every q holds and illegal=0 on that edge.
//   - Latency: one edge from s/r to q; qbar tracks q in the same cycle.
//   - illegal=|(s&r) sampled when en=1. Registered, one cycle wide. Asserted on
//     consecutive cycles if the condition persists.
//   - Bits are fully independent; mixed per-bit requests are all applied on the same edge.
//   - s/r are 'x'-free in normal use. An X on s or r counts as a protocol error (bench checks).
// CONFIGURATION
//   SRFF_ILLEGAL_CNT_EN defined:
//     - Adds output illegal_cnt [7:0]: saturating count of edges where illegal is set (en=1 & |(s&r)).
//     - Counter reset to 0 by rst; saturates at 8'hFF.
//   SRFF_ILLEGAL_CNT_EN undefined:
//     - illegal_cnt port and counter logic absent; all other behaviour identical.
// STRUCTURE
//   - srff_pkg holds: typedef enum sr_policy_e {HOLD, SET_DOM, RST_DOM, TOGGLE}; SRFF_CNT_W = 8.
//   - Sub-module srff_bit: one SR cell (clk, rst, en, s, r -> q) with SR_POLICY and RST_VAL bit.
//     Instantiated WIDTH times via generate.
//   - Top (sr_flip_flop) adds: qbar inversion, illegal reduction/register, optional counter.
// TESTING
//   1 Reset: rst=0 mid-cycle with q=1 (WIDTH=1)
//     -> q=0, qbar=1 immediately, before the next clk edge.
//   2 Truth table, HOLD policy, en=1, release rst, then one edge each:
//     (s,r)=00 -> q=0; 01 -> q=0; 10 -> q=1; 00 -> q=1 (hold); 11 -> q=1, illegal=1 next cycle.
//   3 Policy sweep from q=1, apply s=r=1:
//     SET_DOM -> q=1; RST_DOM -> q=0; TOGGLE -> q alternates 0,1,0 over 3 edges.
//   4 Enable: en=0, s=1 r=0 for 3 edges from q=0 -> q stays 0, illegal=0;
//     en=1 -> q=1 after 1 edge.
//   5 Multi-bit (WIDTH=4, q=4'b0000): s=4'b1010, r=4'b0101 -> q=4'b1010;
//     then s=4'b1000, r=4'b1000 (HOLD) -> q=4'b1010, illegal=1.
//   6 SRFF_ILLEGAL_CNT_EN: 300 consecutive s=r=1 edges -> illegal_cnt=8'hFF;
//     rst=0 -> illegal_cnt=0.
//   All scenarios: qbar==~q checked every cycle.

Source files
------------

// File: rtl/srff_pkg.sv
// Shared types and constants for the sr_flip_flop bank.
// The s=r=1 resolution policy is chosen per instance through sr_policy_e.
package srff_pkg;

    typedef enum logic [1:0] {
        HOLD,
        SET_DOM,
        RST_DOM,
        TOGGLE
    } sr_policy_e;

    localparam int unsigned SRFF_CNT_W = 8;

    // Next state of one SR cell when it is enabled.
    function automatic logic sr_next(sr_policy_e policy, logic q, logic s, logic r);
        logic nxt;
        nxt = q;
        unique case ({s, r})
            2'b00: nxt = q;
            2'b01: nxt = 1'b0;
            2'b10: nxt = 1'b1;
            2'b11: begin
                unique case (policy)
                    HOLD:    nxt = q;
                    SET_DOM: nxt = 1'b1;
                    RST_DOM: nxt = 1'b0;
                    TOGGLE:  nxt = ~q;
                    default: nxt = q;
                endcase
            end
            default: nxt = q;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/srff_bit.sv
// Single clocked SR cell with asynchronous active-low reset and clock enable.
// The s=r=1 case resolves according to SR_POLICY.
module srff_bit
    import srff_pkg::*;
#(
    parameter sr_policy_e SR_POLICY = HOLD,
    parameter logic       RST_VAL   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic s_i,
    input  logic r_i,
    output logic q_o
);

    logic q_d;
    logic q_q;

    always_comb begin
        q_d = q_q;
        if (en_i) begin
            q_d = sr_next(SR_POLICY, q_q, s_i, r_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/sr_flip_flop.sv
// Bank of WIDTH independent SR flip-flops with a registered s=r=1 flag.
// Define SRFF_ILLEGAL_CNT_EN to add a saturating count of flagged edges (illegal_cnt_o).
module sr_flip_flop
    import srff_pkg::*;
#(
    parameter int unsigned      WIDTH     = 1,
    parameter logic [WIDTH-1:0] RST_VAL   = '0,
    parameter sr_policy_e       SR_POLICY = HOLD
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [WIDTH-1:0] s_i,
    input  logic [WIDTH-1:0] r_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] qbar_o,
    output logic             illegal_o
`ifdef SRFF_ILLEGAL_CNT_EN
    ,
    output logic [SRFF_CNT_W-1:0] illegal_cnt_o
`endif
);

    logic [WIDTH-1:0] q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        srff_bit #(
            .SR_POLICY(SR_POLICY),
            .RST_VAL  (RST_VAL[i])
        ) u_bit (
            .clk_i (clk_i),
            .rst_ni(rst_ni),
            .en_i  (en_i),
            .s_i   (s_i[i]),
            .r_i   (r_i[i]),
            .q_o   (q[i])
        );
    end

    assign q_o    = q;
    assign qbar_o = ~q;

    logic illegal_d;
    logic illegal_q;

    assign illegal_d = en_i & (|(s_i & r_i));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal_o = illegal_q;

`ifdef SRFF_ILLEGAL_CNT_EN
    logic [SRFF_CNT_W-1:0] cnt_d;
    logic [SRFF_CNT_W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (illegal_d && (cnt_q != '1)) begin
            cnt_d = cnt_q + SRFF_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign illegal_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_sr_flip_flop.sv
// Bench for sr_flip_flop: five instances (four policies at WIDTH=4, one WIDTH=1)
// share stimulus; a per-cycle reference model plus literal checks cover each rule.
module tb_sr_flip_flop;
    import srff_pkg::*;

    localparam int NI = 5;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] s;
    logic [3:0] r;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    logic [3:0] q0, q1, q2, q3, qb0, qb1, qb2, qb3;
    logic       q4, qb4;
    logic       il [NI];
    logic [3:0] dq [NI];
    logic [3:0] dqb [NI];
`ifdef SRFF_ILLEGAL_CNT_EN
    logic [7:0] dcnt [NI];
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SRFF_ILLEGAL_CNT_EN
    `define TB_CNT(n) , .illegal_cnt_o(dcnt[n])
`else
    `define TB_CNT(n)
`endif

    sr_flip_flop #(.WIDTH(4), .RST_VAL(4'b0000), .SR_POLICY(HOLD)) u_hold (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .s_i(s), .r_i(r),
        .q_o(q0), .qbar_o(qb0), .illegal_o(il[0]) `TB_CNT(0));
    sr_flip_flop #(.WIDTH(4), .RST_VAL(4'b0000), .SR_POLICY(SET_DOM)) u_set (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .s_i(s), .r_i(r),
        .q_o(q1), .qbar_o(qb1), .illegal_o(il[1]) `TB_CNT(1));
    sr_flip_flop #(.WIDTH(4), .RST_VAL(4'b1111), .SR_POLICY(RST_DOM)) u_rst (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .s_i(s), .r_i(r),
        .q_o(q2), .qbar_o(qb2), .illegal_o(il[2]) `TB_CNT(2));
    sr_flip_flop #(.WIDTH(4), .RST_VAL(4'b0110), .SR_POLICY(TOGGLE)) u_tog (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .s_i(s), .r_i(r),
        .q_o(q3), .qbar_o(qb3), .illegal_o(il[3]) `TB_CNT(3));
    sr_flip_flop #(.WIDTH(1), .RST_VAL(1'b0), .SR_POLICY(HOLD)) u_one (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .s_i(s[0]), .r_i(r[0]),
        .q_o(q4), .qbar_o(qb4), .illegal_o(il[4]) `TB_CNT(4));

    assign dq[0] = q0;  assign dqb[0] = qb0;
    assign dq[1] = q1;  assign dqb[1] = qb1;
    assign dq[2] = q2;  assign dqb[2] = qb2;
    assign dq[3] = q3;  assign dqb[3] = qb3;
    assign dq[4] = {3'b000, q4};
    assign dqb[4] = {3'b000, qb4};

    // Reference model
    sr_policy_e pol  [NI] = '{HOLD, SET_DOM, RST_DOM, TOGGLE, HOLD};
    logic [3:0] rval [NI] = '{4'b0000, 4'b0000, 4'b1111, 4'b0110, 4'b0000};
    logic [3:0] mask [NI] = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0001};
    logic [3:0] mq   [NI];
    logic       mil  [NI];
    int         mcnt [NI];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge rst_n) begin
        for (int i = 0; i < NI; i++) begin
            mq[i]   = rval[i];
            mil[i]  = 1'b0;
            mcnt[i] = 0;
        end
    end

    always @(posedge clk) begin
        if (rst_n === 1'b1) begin
            if (cmp_en) chk("sr_known", 32'($isunknown({s, r, en})), 32'd0);
            for (int i = 0; i < NI; i++) begin
                logic [3:0] nq;
                nq = mq[i];
                if (en) begin
                    for (int b = 0; b < 4; b++) begin
                        if (s[b] && r[b]) begin
                            case (pol[i])
                                SET_DOM: nq[b] = 1'b1;
                                RST_DOM: nq[b] = 1'b0;
                                TOGGLE:  nq[b] = ~mq[i][b];
                                default: nq[b] = mq[i][b];
                            endcase
                        end else if (s[b]) begin
                            nq[b] = 1'b1;
                        end else if (r[b]) begin
                            nq[b] = 1'b0;
                        end
                    end
                end
                mq[i]  = nq & mask[i];
                mil[i] = en && ((s & r & mask[i]) != 4'b0000);
                if (mil[i] && mcnt[i] < 255) mcnt[i] = mcnt[i] + 1;
            end
        end
        #1;
        if (cmp_en) begin
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("model_q[%0d]", i), 32'(dq[i]), 32'(mq[i]));
                chk($sformatf("qbar[%0d]", i), 32'(dqb[i]), 32'(~dq[i] & mask[i]));
                chk($sformatf("model_illegal[%0d]", i), 32'(il[i]), 32'(mil[i]));
`ifdef SRFF_ILLEGAL_CNT_EN
                chk($sformatf("model_cnt[%0d]", i), 32'(dcnt[i]), 32'(mcnt[i]));
`endif
            end
        end
    end

    task automatic drive(input logic e, input logic [3:0] sv, input logic [3:0] rv);
        en = e;
        s  = sv;
        r  = rv;
    endtask

    // Advance one edge; checks run at posedge+3, after the model compare.
    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    initial begin
        rst_n = 1'b1;
        drive(1'b0, 4'b0000, 4'b0000);
        #1 rst_n = 1'b0;
        #1;
        cmp_en = 1'b1;
        chk("rst_q_hold", 32'(q0), 32'h0);
        chk("rst_qbar_hold", 32'(qb0), 32'hF);
        chk("rst_q_rstdom", 32'(q2), 32'hF);
        chk("rst_q_toggle", 32'(q3), 32'h6);
        chk("rst_illegal", 32'(il[0]), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        en = 1'b1;

        // Truth table with all bits driven alike
        drive(1'b1, 4'b0000, 4'b0000); tick(); chk("tt_00", 32'(q0), 32'h0);
        drive(1'b1, 4'b0000, 4'b1111); tick(); chk("tt_01", 32'(q0), 32'h0);
        drive(1'b1, 4'b1111, 4'b0000); tick(); chk("tt_10", 32'(q0), 32'hF);
        drive(1'b1, 4'b0000, 4'b0000); tick(); chk("tt_00_hold", 32'(q0), 32'hF);
        chk("tt_no_illegal", 32'(il[0]), 32'h0);
        drive(1'b1, 4'b1111, 4'b1111); tick();
        chk("tt_11_hold", 32'(q0), 32'hF);
        chk("tt_11_illegal", 32'(il[0]), 32'h1);
        chk("pol_setdom", 32'(q1), 32'hF);
        chk("pol_rstdom", 32'(q2), 32'h0);
        chk("pol_toggle_1", 32'(q3), 32'h0);
        tick(); chk("pol_toggle_2", 32'(q3), 32'hF);
        chk("illegal_persist", 32'(il[0]), 32'h1);
        tick(); chk("pol_toggle_3", 32'(q3), 32'h0);

        // Enable gating
        drive(1'b1, 4'b0000, 4'b1111); tick();
        drive(1'b0, 4'b1111, 4'b0000);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("en0_hold", 32'(q0), 32'h0);
            chk("en0_illegal", 32'(il[0]), 32'h0);
        end
        drive(1'b0, 4'b1111, 4'b1111); tick();
        chk("en0_sr11_illegal", 32'(il[0]), 32'h0);
        chk("en0_sr11_toggle", 32'(q3), 32'h0);
        drive(1'b1, 4'b1111, 4'b0000); tick(); chk("en1_set", 32'(q0), 32'hF);

        // Mixed per-bit requests
        drive(1'b1, 4'b0000, 4'b1111); tick();
        drive(1'b1, 4'b1010, 4'b0101); tick(); chk("mixed", 32'(q0), 32'hA);
        drive(1'b1, 4'b1000, 4'b1000); tick();
        chk("mixed_hold", 32'(q0), 32'hA);
        chk("mixed_illegal", 32'(il[0]), 32'h1);
        chk("mixed_toggle", 32'(q3), 32'h2);
        drive(1'b1, 4'b0000, 4'b0000); tick();
        chk("illegal_pulse_end", 32'(il[0]), 32'h0);

        // Asynchronous reset mid-cycle on the 1-bit instance
        drive(1'b1, 4'b0001, 4'b0000); tick(); chk("one_set", 32'(q4), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_q", 32'(q4), 32'h0);
        chk("async_qbar", 32'(qb4), 32'h1);
        chk("async_hold_q", 32'(q0), 32'h0);
        tick(); chk("rst_held_q", 32'(q4), 32'h0);
        rst_n = 1'b1;

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            drive(($urandom_range(0, 7) != 0), 4'($urandom), 4'($urandom));
            tick();
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end

`ifdef SRFF_ILLEGAL_CNT_EN
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        drive(1'b1, 4'b1111, 4'b1111);
        for (int k = 0; k < 300; k++) begin
            tick();
            if (k == 0) chk("cnt_first", 32'(dcnt[0]), 32'h1);
        end
        chk("cnt_sat", 32'(dcnt[0]), 32'hFF);
        rst_n = 1'b0;
        #1;
        chk("cnt_rst", 32'(dcnt[0]), 32'h0);
        rst_n = 1'b1;
`endif

        drive(1'b0, 4'b0000, 4'b0000);
        tick();
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
